ps2_keyboard_rx: RTL and testbench

//  Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes Set-2 make/break/extended prefixes.

---
 rtl/ps2_keyboard_rx.sv | 174 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, clock glitch filter, frame FSM, Set-2 decode, event FIFO.
// Ports: Clock/Reset; raw ps2_clk/ps2_data; key_valid/key_ready/key_data/key_release/key_ext; frame_err; overflow.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_data,
  output logic       key_release,
  output logic       key_ext,
  output logic       frame_err,
  output logic       overflow
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic filt, filt_d, fall;
  logic [FW-1:0] fcnt;

  state_t state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic par, brk, ext;
  logic [TW-1:0] tcnt;

  logic good, push, pop, full, push_ok;
  logic [9:0] mem [FIFO_DEPTH];
  logic [9:0] head;
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;

  // Idle PS/2 lines are high, so sync flops reset high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Level must differ for FILTER_LEN consecutive cycles to be accepted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= '0;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_s2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  assign fall = filt_d & ~filt;

  // Odd parity over data+parity, and stop bit must be high.
  assign good = dat_s2 & (^{shreg, par});
  assign push = fall && (state == STOP) && good &&
                (shreg != 8'hF0) && (shreg != 8'hE0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!good) begin
              frame_err <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext <= 1'b1;
            end else begin
              brk <= 1'b0;
              ext <= 1'b0;
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
          brk       <= 1'b0;
          ext       <= 1'b0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign full    = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop     = key_valid & key_ready;
  assign push_ok = push & (~full | pop);

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr] <= {ext, brk, shreg};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr       <= '0;
      rd       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & ~push_ok) overflow <= 1'b1;
    end
  end

  assign key_valid   = (count != '0);
  assign head        = key_valid ? mem[rd] : '0;
  assign key_data    = head[7:0];
  assign key_release = head[8];
  assign key_ext     = head[9];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: queue-based event model, per-cycle compare, directed and random frames.
// Drives raw PS/2 pins from the bench; no DUT ports are read back into the model.
module tb_ps2_keyboard_rx;
  localparam int TO    = 400;
  localparam int DEPTH = 4;
  localparam int H     = 14;
  localparam int LAT   = 11;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic key_ready = 1'b0;
  logic key_valid, key_release, key_ext, frame_err, overflow;
  logic [7:0] key_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] mq[$];
  bit m_ovf = 0;
  bit m_brk = 0;
  bit m_ext = 0;
  int sch_cyc = -1;
  bit sch_err = 0;
  logic [9:0] sch_ev = '0;
  bit exp_err = 0;
  bit chk_err = 1;
  bit rand_mode = 0;
  int err_pulses = 0;
  int last_stop_cyc = 0;
  int rise_cyc = 0;
  bit kv_prev = 0;

  ps2_keyboard_rx #(.FILTER_LEN(8), .TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .key_release(key_release), .key_ext(key_ext),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Event model: pops on handshake, applies scheduled frame results.
  always @(posedge Clock) begin : mdl
    bit pop;
    cyc++;
    exp_err = 0;
    if (Reset) begin
      mq.delete();
      m_ovf = 0;
      m_brk = 0;
      m_ext = 0;
      sch_cyc = -1;
    end else begin
      pop = (mq.size() > 0) && (key_ready === 1'b1);
      if (pop) void'(mq.pop_front());
      if (sch_cyc == cyc) begin
        if (sch_err) exp_err = 1;
        else if (mq.size() < DEPTH) mq.push_back(sch_ev);
        else m_ovf = 1;
        sch_cyc = -1;
      end
    end
  end

  always @(negedge Clock) begin
    if (cyc >= 1) begin
      chk("key_valid", key_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("key_data", key_data, mq[0][7:0]);
        chk("key_release", key_release, mq[0][8]);
        chk("key_ext", key_ext, mq[0][9]);
      end
      chk("overflow", overflow, m_ovf);
      if (chk_err) chk("frame_err", frame_err, exp_err);
      if (frame_err === 1'b1) err_pulses++;
      if (key_valid === 1'b1 && !kv_prev) rise_cyc = cyc;
      kv_prev = (key_valid === 1'b1);
    end
  end

  always @(negedge Clock) begin
    if (rand_mode) key_ready = 1'($urandom_range(0, 1));
  end

  task automatic model_stop(logic [7:0] b, bit ok);
    last_stop_cyc = cyc;
    if (!ok) begin
      sch_err = 1;
      sch_cyc = cyc + LAT;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
      sch_err = 0;
      sch_ev  = {m_ext, m_brk, b};
      sch_cyc = cyc + LAT;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop);
    logic p;
    logic [10:0] fr;
    p  = (~^b) ^ bad_par;
    fr = {~bad_stop, p, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      repeat (H) @(negedge Clock);
      ps2_clk = 1'b0;
      if (i == 10) model_stop(b, !bad_par && !bad_stop);
      repeat (H) @(negedge Clock);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (H) @(negedge Clock);
  endtask

  task automatic send_partial(int n);
    logic [7:0] r;
    r = 8'($urandom);
    for (int i = 0; i <= n; i++) begin
      ps2_data = (i == 0) ? 1'b0 : r[i-1];
      repeat (H) @(negedge Clock);
      ps2_clk = 1'b0;
      repeat (H) @(negedge Clock);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    key_ready = 1'b1;
    repeat (8) @(negedge Clock);
    key_ready = 1'b0;
    @(negedge Clock);
  endtask

  task automatic pop_one();
    key_ready = 1'b1;
    @(negedge Clock);
    key_ready = 1'b0;
  endtask

  initial begin : main
    logic [7:0] exp4 [4];
    int p0;
    exp4 = '{8'h15, 8'h1D, 8'h24, 8'h2D};

    repeat (3) @(negedge Clock);
    chk("rst_valid", key_valid, 0);
    chk("rst_data", key_data, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock);

    send_frame(8'h1C, 0, 0);
    chk("lit_1c_valid", key_valid, 1);
    chk("lit_1c_data", key_data, 8'h1C);
    chk("lit_1c_flags", {key_ext, key_release}, 2'b00);
    chk("lit_latency", rise_cyc - last_stop_cyc, LAT);
    chk("model_1c", mq[0], 10'h01C);
    drain();

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    chk("lit_brk_count", mq.size(), 1);
    chk("lit_brk_data", key_data, 8'h1C);
    chk("lit_brk_flags", {key_ext, key_release}, 2'b01);
    drain();

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    chk("lit_ext_data", key_data, 8'h75);
    chk("lit_ext_flags", {key_ext, key_release}, 2'b11);
    drain();

    p0 = err_pulses;
    send_frame(8'h1C, 1, 0);
    chk("lit_par_pulses", err_pulses - p0, 1);
    chk("lit_par_noevent", key_valid, 0);
    send_frame(8'h32, 0, 0);
    chk("lit_32_data", key_data, 8'h32);
    chk("lit_32_rel", key_release, 0);
    drain();

    send_frame(8'h15, 0, 0);
    send_frame(8'h1D, 0, 0);
    send_frame(8'h24, 0, 0);
    send_frame(8'h2D, 0, 0);
    chk("lit_4_ovf", overflow, 0);
    send_frame(8'h2C, 0, 0);
    chk("lit_5_ovf", overflow, 1);
    chk("model_held", mq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("lit_fifo_order", key_data, exp4[i]);
      pop_one();
    end
    chk("lit_fifo_empty", key_valid, 0);

    send_frame(8'hF0, 0, 0);
    chk_err = 0;
    p0 = err_pulses;
    send_partial(4);
    repeat (TO + 80) @(negedge Clock);
    chk("lit_timeout_pulses", err_pulses - p0, 1);
    m_brk = 0;
    m_ext = 0;
    chk_err = 1;
    send_frame(8'h1C, 0, 0);
    chk("lit_to_data", key_data, 8'h1C);
    chk("lit_to_rel", key_release, 0);
    drain();

    ps2_data = 1'b0;
    repeat (H) @(negedge Clock);
    ps2_clk = 1'b0;
    repeat (7) @(negedge Clock);
    ps2_clk = 1'b1;
    repeat (H) @(negedge Clock);
    ps2_data = 1'b1;
    repeat (H) @(negedge Clock);
    send_frame(8'h24, 0, 0);
    chk("lit_glitch_data", key_data, 8'h24);
    chk("lit_glitch_count", mq.size(), 1);

    send_frame(8'hF0, 0, 0);
    send_partial(3);
    Reset = 1'b1;
    repeat (4) @(negedge Clock);
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    Reset = 1'b0;
    p0 = err_pulses;
    repeat (TO + 40) @(negedge Clock);
    chk("mid_rst_noerr", err_pulses - p0, 0);
    send_frame(8'h1C, 0, 0);
    chk("post_rst_data", key_data, 8'h1C);
    chk("post_rst_rel", key_release, 0);
    drain();

    rand_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int sel;
      b = 8'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0) b = 8'hF0;
      else if (sel == 1) b = 8'hE0;
      send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 20)) @(negedge Clock);
    end
    rand_mode = 0;
    key_ready = 1'b1;
    repeat (40) @(negedge Clock);
    chk("final_empty", key_valid, 0);
    chk("final_model_empty", mq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
